// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the GBM Monte Carlo lane:
// fixed-point word format and scheduler FSM state type.
package fpga_cfg_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_QFRAC = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } gbm_sched_state_t;

endpackage

// File: rtl/gbm_path_scheduler_if.sv
// Scheduler bundle: control, normal-variate stream,
// GBM issue/result handshakes and observation stream.
interface gbm_path_scheduler_if #(
  parameter int WIDTH  = 32,
  parameter int NPATHS = 8,
  parameter int NSTEPS = 16
);
  localparam int PW = $clog2(NPATHS);
  localparam int SW = $clog2(NSTEPS + 1);

  logic                    start;
  logic signed [WIDTH-1:0] s0;
  logic signed [WIDTH-1:0] r;
  logic signed [WIDTH-1:0] sigma;
  logic signed [WIDTH-1:0] dt;
  logic                    busy;
  logic                    done;

  logic                    z_valid;
  logic                    z_ready;
  logic signed [WIDTH-1:0] z;

  logic                    gbm_valid;
  logic                    gbm_ready;
  logic signed [WIDTH-1:0] gbm_z;
  logic signed [WIDTH-1:0] gbm_S;
  logic signed [WIDTH-1:0] gbm_r;
  logic signed [WIDTH-1:0] gbm_sigma;
  logic signed [WIDTH-1:0] gbm_dt;

  logic                    res_valid;
  logic                    res_ready;
  logic signed [WIDTH-1:0] res_S;

  logic                    obs_valid;
  logic                    obs_ready;
  logic [PW-1:0]           obs_path;
  logic [SW-1:0]           obs_step;
  logic [WIDTH-1:0]        obs_S;

  modport slave (
    input  start, s0, r, sigma, dt,
    input  z_valid, z, gbm_ready,
    input  res_valid, res_S, obs_ready,
    output busy, done, z_ready,
    output gbm_valid, gbm_z, gbm_S,
    output gbm_r, gbm_sigma, gbm_dt,
    output res_ready, obs_valid,
    output obs_path, obs_step, obs_S
  );

  modport master (
    output start, s0, r, sigma, dt,
    output z_valid, z, gbm_ready,
    output res_valid, res_S, obs_ready,
    input  busy, done, z_ready,
    input  gbm_valid, gbm_z, gbm_S,
    input  gbm_r, gbm_sigma, gbm_dt,
    input  res_ready, obs_valid,
    input  obs_path, obs_step, obs_S
  );

endinterface

// File: rtl/path_state_rf.sv
// Per-path price store: NPATHS x WIDTH, one async read,
// one write, broadcast init (i_init wins over i_we).
module path_state_rf #(
  parameter int WIDTH  = 32,
  parameter int NPATHS = 8,
  parameter int AW     = $clog2(NPATHS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init,
  input  logic [WIDTH-1:0] i_init_val,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [NPATHS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPATHS; i++)
        r_mem[i] <= '0;
    end else if (i_init) begin
      for (int i = 0; i < NPATHS; i++)
        r_mem[i] <= i_init_val;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gbm_path_scheduler.sv
// Round-robin path scheduler for one GBM_step lane:
// clk/rst_n plus the gbm_path_scheduler_if slave bundle.
module gbm_path_scheduler
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int QFRAC   = FP_QFRAC,
  parameter int NPATHS  = 8,
  parameter int NSTEPS  = 16,
  parameter int LANE_ID = 0
) (
  input  logic clk,
  input  logic rst_n,
  gbm_path_scheduler_if.slave sch
);

  localparam int PW = $clog2(NPATHS);
  localparam int SW = $clog2(NSTEPS + 1);
  localparam int IW = $clog2(NPATHS + 1);
  localparam logic [PW-1:0] LAST_P = PW'(NPATHS - 1);
  localparam logic [SW-1:0] LAST_S = SW'(NSTEPS - 1);
  localparam logic [IW-1:0] MAX_IF = IW'(NPATHS);

  // QFRAC/LANE_ID are carried only as tags
  if (QFRAC < 0 || QFRAC > WIDTH || LANE_ID < 0)
  begin : g_cfg_unused
  end

  typedef struct packed {
    logic [PW-1:0]    path;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] s;
  } obs_t;

  gbm_sched_state_t r_state;
  gbm_sched_state_t w_next;

  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_sigma;
  logic [WIDTH-1:0] r_dt;
  logic [PW-1:0]    r_iss_path;
  logic [SW-1:0]    r_iss_step;
  logic [PW-1:0]    r_ret_path;
  logic [SW-1:0]    r_ret_step;
  logic [IW-1:0]    r_inflight;
  logic             r_ret_done;
  logic             r_obs_valid;
  obs_t             r_obs;

  logic             w_start;
  logic             w_active;
  logic             w_gbm_valid;
  logic             w_iss_fire;
  logic             w_res_ready;
  logic             w_res_fire;
  logic             w_last_iss;
  logic             w_last_ret;
  logic [WIDTH-1:0] w_rd;

  assign w_start     = (r_state == S_IDLE) && sch.start;
  assign w_active    = (r_state == S_RUN) ||
                       (r_state == S_DRAIN);
  assign w_gbm_valid = (r_state == S_RUN) &&
                       sch.z_valid &&
                       (r_inflight < MAX_IF);
  assign w_iss_fire  = w_gbm_valid && sch.gbm_ready;
  assign w_res_ready = w_active &&
                       (!r_obs_valid || sch.obs_ready);
  assign w_res_fire  = sch.res_valid && w_res_ready;
  assign w_last_iss  = w_iss_fire &&
                       (r_iss_path == LAST_P) &&
                       (r_iss_step == LAST_S);
  assign w_last_ret  = w_res_fire &&
                       (r_ret_path == LAST_P) &&
                       (r_ret_step == LAST_S);

  path_state_rf #(
    .WIDTH (WIDTH),
    .NPATHS(NPATHS),
    .AW    (PW)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_init    (w_start),
    .i_init_val(sch.s0),
    .i_we      (w_res_fire),
    .i_waddr   (r_ret_path),
    .i_wdata   (sch.res_S),
    .i_raddr   (r_iss_path),
    .o_rdata   (w_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // DONE waits until the final observation has left
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (sch.start) w_next = S_RUN;
      S_RUN:   if (w_last_iss) w_next = S_DRAIN;
      S_DRAIN: if (r_ret_done &&
                   (!r_obs_valid || sch.obs_ready))
                 w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sch.busy = 1'b0;
    sch.done = 1'b0;
    unique case (r_state)
      S_RUN:   sch.busy = 1'b1;
      S_DRAIN: sch.busy = 1'b1;
      S_DONE: begin
        sch.busy = 1'b1;
        sch.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= '0;
      r_sigma     <= '0;
      r_dt        <= '0;
      r_iss_path  <= '0;
      r_iss_step  <= '0;
      r_ret_path  <= '0;
      r_ret_step  <= '0;
      r_inflight  <= '0;
      r_ret_done  <= 1'b0;
      r_obs_valid <= 1'b0;
      r_obs       <= '0;
    end else if (w_start) begin
      r_r         <= sch.r;
      r_sigma     <= sch.sigma;
      r_dt        <= sch.dt;
      r_iss_path  <= '0;
      r_iss_step  <= '0;
      r_ret_path  <= '0;
      r_ret_step  <= '0;
      r_inflight  <= '0;
      r_ret_done  <= 1'b0;
      r_obs_valid <= 1'b0;
    end else begin
      if (w_iss_fire) begin
        if (r_iss_path == LAST_P) begin
          r_iss_path <= '0;
          r_iss_step <= r_iss_step + SW'(1);
        end else begin
          r_iss_path <= r_iss_path + PW'(1);
        end
      end
      if (w_res_fire) begin
        r_obs.path  <= r_ret_path;
        r_obs.step  <= r_ret_step + SW'(1);
        r_obs.s     <= sch.res_S;
        r_obs_valid <= 1'b1;
        if (r_ret_path == LAST_P) begin
          r_ret_path <= '0;
          r_ret_step <= r_ret_step + SW'(1);
        end else begin
          r_ret_path <= r_ret_path + PW'(1);
        end
      end else if (sch.obs_ready) begin
        r_obs_valid <= 1'b0;
      end
      if (w_last_ret) r_ret_done <= 1'b1;
      case ({w_iss_fire, w_res_fire})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: ;
      endcase
    end
  end

  assign sch.gbm_valid = w_gbm_valid;
  assign sch.z_ready   = w_iss_fire;
  assign sch.gbm_z     = w_gbm_valid ? sch.z : '0;
  assign sch.gbm_S     = w_rd;
  assign sch.gbm_r     = r_r;
  assign sch.gbm_sigma = r_sigma;
  assign sch.gbm_dt    = r_dt;
  assign sch.res_ready = w_res_ready;
  assign sch.obs_valid = r_obs_valid;
  assign sch.obs_path  = r_obs.path;
  assign sch.obs_step  = r_obs.step;
  assign sch.obs_S     = r_obs.s;

endmodule
